// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M-style multiply/divide unit, WIDTH-parametrised
//
// Purpose : multi-cycle MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU beside the ALU.
//           Radix-2 shift-add multiply and restoring divide share one 2*WIDTH
//           accumulator; signed operands are reduced to magnitudes on accept and
//           the sign is restored in the cycle that enters DONE.
// Option  : `define MULDIV_FAST_MUL_EN makes all multiplies single-cycle
//           (combinational product registered on accept); division is unchanged.
// Ports   : clk, rst (async, active-high)
//           in_valid/in_ready, op[2:0] (funct3), a, b   - request
//           out_valid/out_ready, result                 - response
//           busy                                        - high in CALC or DONE
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [2:0]         op_r;
  logic               sa_r, sb_r;
  logic [WIDTH-1:0]   ma_r, mb_r;
  // Multiply: {partial_hi, multiplier_lo}. Divide: {remainder, quotient/dividend}.
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  // Restores the sign of the unsigned core result and picks the result word.
  function automatic logic [WIDTH-1:0] fixup(input logic [2:0] f, input logic sa,
                                             input logic sb, input logic [2*WIDTH-1:0] p);
    logic [2*WIDTH-1:0] pn;
    logic [WIDTH-1:0]   q, r;
    pn = -p;
    q  = p[WIDTH-1:0];
    r  = p[2*WIDTH-1:WIDTH];
    case (f)
      OP_MUL:    fixup = p[WIDTH-1:0];
      OP_MULH:   fixup = (sa ^ sb) ? pn[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
      OP_MULHSU: fixup = sa ? pn[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
      OP_MULHU:  fixup = p[2*WIDTH-1:WIDTH];
      OP_DIV:    fixup = (sa ^ sb) ? -q : q;
      OP_DIVU:   fixup = q;
      OP_REM:    fixup = sa ? -r : r;
      default:   fixup = r;
    endcase
  endfunction

  // Accept-side decode
  logic             sa, sb, div0, ovf, special;
  logic [WIDTH-1:0] ma, mb, special_res;

  always_comb begin
    sa = a[WIDTH-1] && (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
    sb = b[WIDTH-1] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
    // Negating the most-negative value leaves 2^(WIDTH-1), the correct magnitude.
    ma = sa ? -a : a;
    mb = sb ? -b : b;
    div0 = op[2] && (b == '0);
    ovf  = (op == OP_DIV || op == OP_REM) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    special = div0 || ovf;
    // op[1] distinguishes REM/REMU from DIV/DIVU.
    if (div0) special_res = op[1] ? a : '1;
    else      special_res = op[1] ? '0 : a;
  end

  // One iteration of the shared core
  logic [WIDTH:0]     mul_add, div_sh, div_diff;
  logic [2*WIDTH-1:0] step_next;

  always_comb begin
    mul_add  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ma_r} : '0);
    div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_sh - {1'b0, mb_r};
    if (!op_r[2])          step_next = {mul_add, acc[WIDTH-1:1]};
    else if (div_diff[WIDTH]) step_next = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else                   step_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, ma} * {{WIDTH{1'b0}}, mb};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      op_r      <= '0;
      sa_r      <= 1'b0;
      sb_r      <= 1'b0;
      ma_r      <= '0;
      mb_r      <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r     <= op;
            sa_r     <= sa;
            sb_r     <= sb;
            ma_r     <= ma;
            mb_r     <= mb;
            acc      <= {{WIDTH{1'b0}}, (op[2] ? ma : mb)};
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (special) begin
              result    <= special_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!op[2]) begin
              result    <= fixup(op, sa, sb, fast_prod);
              out_valid <= 1'b1;
              state     <= DONE;
            end
`endif
            else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= step_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) begin
            result    <= fixup(op_r, sa_r, sb_r, step_next);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int total = 0;
  int bad   = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = f; a = x; b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".result"}, 64'(result), 64'(exp));
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".ov_clr"}, 64'(out_valid), 64'd0);
    chk({tag, ".idle"}, 64'(in_ready), 64'd1);
    chk({tag, ".hold"}, 64'(result), 64'(exp));
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.result", 64'(result), 64'd0);
    rst = 1'b0;

    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
    run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT);
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",   3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33);
    run_op("div0",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem0",   3'b110, 32'd5,        32'd0,        32'd5,        1);
    run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Backpressure: REMU 100 % 7 = 2 held in DONE while new requests are offered.
    @(negedge clk);
    in_valid = 1'b1; op = 3'b111; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    chk("bp.lat", 64'(lat), 64'd33);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; op = 3'b000; a = 32'd3 + 32'(i); b = 32'd3;
      @(negedge clk);
      chk("bp.out_valid", 64'(out_valid), 64'd1);
      chk("bp.result", 64'(result), 64'd2);
      chk("bp.in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp.ov_clr", 64'(out_valid), 64'd0);
    chk("bp.idle", 64'(in_ready), 64'd1);
    chk("bp.busy", 64'(busy), 64'd0);
    chk("bp.hold", 64'(result), 64'd2);
    repeat (2) @(negedge clk);
    chk("bp.no_ghost", 64'(out_valid), 64'd0);

    // Reset while CALC counter is at 15.
    @(negedge clk);
    in_valid = 1'b1; op = 3'b101; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("mid.busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid.in_ready", 64'(in_ready), 64'd1);
    chk("mid.out_valid", 64'(out_valid), 64'd0);
    chk("mid.busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("mid.no_ov", 64'(out_valid), 64'd0);
    run_op("divu2", 3'b101, 32'd100, 32'd7, 32'd14, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
